// File: rtl/aes_pkg.sv
// Shared AES constants: widths, S-box, Rcon, MixColumns helpers.
// Imported by the AES-256 encrypt core, its interface and S-box.
package aes_pkg;

  localparam int DATA_W = 128;
  localparam int KEY_W  = 256;
  localparam int ROUNDS = 14;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } fsm_t;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry 0 is unused; the schedule only indexes 1..7.
  localparam logic [0:7][7:0] RCON = {
    8'h00, 8'h01, 8'h02, 8'h04,
    8'h08, 8'h10, 8'h20, 8'h40
  };

  function automatic logic [7:0] xtime(
    input logic [7:0] b
  );
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_column(
    input logic [31:0] c
  );
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] r0, r1, r2, r3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    r0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    r1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    r2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    r3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {r0, r1, r2, r3};
  endfunction

endpackage

// File: rtl/aes256_encrypt_core_if.sv
// Request/response bundle of the AES-256 encrypt core.
// master drives plaintext/key, slave is the core.
interface aes256_encrypt_core_if;
  import aes_pkg::*;

  logic              data_valid_in;
  logic [DATA_W-1:0] plain_text;
  logic              key_valid_in;
  logic [KEY_W-1:0]  cipher_key;
  logic              data_valid_out;
  logic [DATA_W-1:0] cipher_text;

  modport master (
    output data_valid_in,
    output plain_text,
    output key_valid_in,
    output cipher_key,
    input  data_valid_out,
    input  cipher_text
  );

  modport slave (
    input  data_valid_in,
    input  plain_text,
    input  key_valid_in,
    input  cipher_key,
    output data_valid_out,
    output cipher_text
  );

endinterface

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box lookup.
// One byte in, one substituted byte out.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);

  assign y = SBOX[a];

endmodule

// File: rtl/aes256_encrypt_core.sv
// Iterative AES-256 encryptor, one round per clock, on-the-fly keys.
// AES_KEY_REUSE_EN: retain the loaded key for data-only starts.
module aes256_encrypt_core
  import aes_pkg::*;
#(
  parameter int KEY_LEN       = 256,
  parameter int DATA_LEN      = 128,
  parameter int NUMS_OF_ROUND = 14
) (
  input logic                 clk,
  input logic                 reset,
  aes256_encrypt_core_if.slave bus
);

  if (KEY_LEN != 256 || DATA_LEN != 128 ||
      NUMS_OF_ROUND != 14) begin : g_bad_cfg
    $error("aes256_encrypt_core: only 256/128/14");
  end

  fsm_t          fsm;
  logic [3:0]    round;
  logic [127:0]  st;
  logic [255:0]  kw;
  logic [127:0]  ct_q;
  logic          dv_q;

  logic [127:0]  sb, sr, mc, nxt;
  logic          last;
  logic [3:0]    kidx;
  logic [31:0]   sw, t;
  logic [31:0]   n0, n1, n2, n3;
  logic [255:0]  kw_nxt;
  logic          start;
  logic [255:0]  key_sel;

  assign bus.data_valid_out = dv_q;
  assign bus.cipher_text    = ct_q;

  for (genvar g = 0; g < 16; g++) begin : g_sub
    aes_sbox u_sbox (
      .a (st[127-8*g -: 8]),
      .y (sb[127-8*g -: 8])
    );
  end

  // Byte g sits at row g%4, column g/4; row r rotates left by r.
  for (genvar g = 0; g < 16; g++) begin : g_shift
    localparam int R = g % 4;
    localparam int C = g / 4;
    localparam int S = R + 4 * ((C + R) % 4);
    assign sr[127-8*g -: 8] = sb[127-8*S -: 8];
  end

  for (genvar c = 0; c < 4; c++) begin : g_mix
    assign mc[127-32*c -: 32] =
      mix_column(sr[127-32*c -: 32]);
  end

  assign last = (round == 4'(NUMS_OF_ROUND));
  assign nxt  = (last ? sr : mc) ^ kw[127:0];

  // Window is {rk[k-2], rk[k-1]}; build rk[k] from its last word.
  assign kidx = round + 4'd1;

  for (genvar b = 0; b < 4; b++) begin : g_ksub
    aes_sbox u_sbox (
      .a (kw[31-8*b -: 8]),
      .y (sw[31-8*b -: 8])
    );
  end

  assign t = kidx[0] ? sw :
    ({sw[23:0], sw[31:24]} ^
     {RCON[kidx[3:1]], 24'h0});

  assign n0 = kw[255:224] ^ t;
  assign n1 = kw[223:192] ^ n0;
  assign n2 = kw[191:160] ^ n1;
  assign n3 = kw[159:128] ^ n2;
  assign kw_nxt = {kw[127:0], n0, n1, n2, n3};

`ifdef AES_KEY_REUSE_EN
  logic [255:0] key_q;
  logic         key_ok;

  assign start = bus.data_valid_in &
                 (bus.key_valid_in | key_ok);
  assign key_sel = bus.key_valid_in ?
                   bus.cipher_key : key_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      key_q  <= '0;
      key_ok <= 1'b0;
    end else if (fsm == IDLE && bus.key_valid_in) begin
      key_q  <= bus.cipher_key;
      key_ok <= 1'b1;
    end
  end
`else
  assign start   = bus.data_valid_in & bus.key_valid_in;
  assign key_sel = bus.cipher_key;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm   <= IDLE;
      round <= '0;
      st    <= '0;
      kw    <= '0;
      ct_q  <= '0;
      dv_q  <= 1'b0;
    end else begin
      unique case (fsm)
        IDLE: begin
          dv_q <= 1'b0;
          if (start) begin
            st    <= bus.plain_text ^ key_sel[255:128];
            kw    <= key_sel;
            round <= 4'd1;
            fsm   <= RUN;
          end
        end
        RUN: begin
          st    <= nxt;
          kw    <= kw_nxt;
          round <= round + 4'd1;
          if (last) begin
            ct_q <= nxt;
            dv_q <= 1'b1;
            fsm  <= DONE;
          end
        end
        DONE: begin
          dv_q <= 1'b0;
          fsm  <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes256_encrypt_core.sv
// Bench for aes256_encrypt_core: FIPS-197 byte-level reference model,
// scoreboard of expected pulse cycles, per-cycle output compare.
module tb_aes256_encrypt_core;

  localparam logic [255:0] K1 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT1 =
    128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] PT2 =
    128'h014730f80ac625fe84f026c60bfd547d;
  localparam logic [127:0] PT3 =
    128'hf34481ec3cc627bacd5dc3fb08f273e6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  aes256_encrypt_core_if bus ();

  aes256_encrypt_core dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] sbx [256];

  typedef struct {
    int           due;
    logic [127:0] ct;
  } exp_t;

  exp_t         sb_q [$];
  logic [127:0] exp_ct = '0;
  bit           chk_en = 1'b0;

  task automatic check(input string name,
                       input logic [127:0] act,
                       input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h",
               name, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box from GF(2^8) inverse plus affine map.
  task automatic build_sbox();
    logic [7:0] inv, r, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      r = inv;
      s = inv;
      for (int k = 0; k < 4; k++) begin
        r = {r[6:0], r[7]};
        s ^= r;
      end
      sbx[x] = s ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] v);
    return {sbx[v[31:24]], sbx[v[23:16]],
            sbx[v[15:8]], sbx[v[7:0]]};
  endfunction

  function automatic logic [127:0] model(input logic [127:0] pt,
                                         input logic [255:0] key);
    logic [31:0] w [60];
    logic [7:0]  rc = 8'h01;
    logic [31:0] t;
    logic [7:0]  s [16];
    logic [7:0]  u [16];
    logic [7:0]  a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (i % 8 == 4) begin
        t = subw(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int i = 0; i < 16; i++)
      s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 14; r++) begin
      for (int i = 0; i < 16; i++)
        u[i] = sbx[s[(i%4) + 4*(((i/4) + (i%4)) % 4)]];
      for (int c = 0; c < 4; c++) begin
        a0 = u[4*c]; a1 = u[4*c+1];
        a2 = u[4*c+2]; a3 = u[4*c+3];
        if (r < 14) begin
          s[4*c]   = gmul(a0,2) ^ gmul(a1,3) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1,2) ^ gmul(a2,3) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2,2) ^ gmul(a3,3);
          s[4*c+3] = gmul(a0,3) ^ a1 ^ a2 ^ gmul(a3,2);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1;
          s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++)
        s[i] ^= w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  // Per-cycle compare against the scoreboard.
  always @(negedge clk) begin
    bit exp_v;
    if (chk_en) begin
      exp_v = (sb_q.size() > 0) && (sb_q[0].due == cyc);
      if (exp_v) begin
        exp_ct = sb_q[0].ct;
        void'(sb_q.pop_front());
      end
      check("data_valid_out", 128'(bus.data_valid_out),
            128'(exp_v));
      check("cipher_text", bus.cipher_text, exp_ct);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Called at negedge+1; acceptance edge is cyc+1, pulse seen at +14.
  task automatic drive(input bit dv, input bit kv,
                       input logic [127:0] pt,
                       input logic [255:0] key,
                       input bit expect_start);
    exp_t e;
    bus.data_valid_in = dv;
    bus.key_valid_in  = kv;
    bus.plain_text    = pt;
    bus.cipher_key    = key;
    if (expect_start) begin
      e.due = cyc + 15;
      e.ct  = model(pt, key);
      sb_q.push_back(e);
    end
  endtask

  task automatic idle_inputs();
    bus.data_valid_in = 1'b0;
    bus.key_valid_in  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sb_q.delete();
    exp_ct = '0;
    tick(1);
    reset = 1'b0;
  endtask

  initial begin
    exp_t e;
    logic [127:0] ct3;
    idle_inputs();
    bus.plain_text = '0;
    bus.cipher_key = '0;
    build_sbox();

    check("model_fips_c3", model(PT1, K1),
          128'h8ea2b7ca516745bfeafc49904b496089);
    check("model_gfsbox", model(PT2, '0),
          128'h5c9d844ed46f9885085e5d6a4f94c7d7);

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset_valid", 128'(bus.data_valid_out), 128'h0);
    check("reset_ct", bus.cipher_text, 128'h0);
    chk_en = 1'b1;
    reset = 1'b0;
    tick(2);

    drive(1'b1, 1'b1, PT1, K1, 1'b1);
    tick(1);
    idle_inputs();
    tick(20);

    drive(1'b1, 1'b1, PT2, '0, 1'b1);
    tick(1);
    idle_inputs();
    tick(20);

    // Valids held: acceptances every 16 cycles, 7 within 100 edges.
    ct3 = model(PT3, '0);
    drive(1'b1, 1'b1, PT3, '0, 1'b0);
    for (int k = 0; k < 7; k++) begin
      e.due = cyc + 15 + 16 * k;
      e.ct  = ct3;
      sb_q.push_back(e);
    end
    tick(100);
    idle_inputs();
    tick(20);

    // Reset lands on the round-7 edge.
    drive(1'b1, 1'b1, PT2, K1, 1'b1);
    tick(1);
    idle_inputs();
    tick(6);
    do_reset();
    tick(3);
    drive(1'b1, 1'b1, PT1, K1, 1'b1);
    tick(1);
    idle_inputs();
    tick(20);

    do_reset();
    tick(1);
    drive(1'b1, 1'b0, PT1, K1, 1'b0);
    tick(20);
    idle_inputs();
    tick(2);

    drive(1'b0, 1'b1, PT2, K1, 1'b0);
    tick(1);
    idle_inputs();
    tick(2);
`ifdef AES_KEY_REUSE_EN
    drive(1'b1, 1'b0, PT1, '0, 1'b0);
    e.due = cyc + 15;
    e.ct  = model(PT1, K1);
    sb_q.push_back(e);
`else
    drive(1'b1, 1'b0, PT1, '0, 1'b0);
`endif
    tick(1);
    idle_inputs();
    tick(20);

    check("scoreboard_drained", 128'(sb_q.size()), 128'h0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
